// File: rtl/key_load_sequencer.sv
// Key load sequencer for a logic-locked controller FSM.
// Fetches the key serially (LSB first plus one even-parity bit) over a
// valid/ready handshake. A checked key is presented on key_out, and the
// locked FSM is held in reset until the release delay has elapsed.
module key_load_sequencer #(
    parameter int KEY_W       = 8,
    parameter int RELEASE_CYC = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rekey,
    input  logic             key_bit_valid,
    input  logic             key_bit,
    output logic             key_bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_out_valid,
    output logic             fsm_rst,
    output logic             busy,
    output logic             err
);

    localparam int CW = $clog2(KEY_W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RELEASE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t           state_reg, state_next;
    logic [KEY_W-1:0] shreg_reg, shreg_next;
    logic             par_reg, par_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [TW-1:0]    stall_reg, stall_next;
    logic [RW-1:0]    rel_reg, rel_next;
    logic [KEY_W-1:0] key_out_reg, key_out_next;
    logic             key_valid_reg, key_valid_next;
    logic             fsm_rst_reg, fsm_rst_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             err_reg, err_next;
    logic             xfer;

    // ready is a registered copy of (state == LOAD), so this is a real handshake
    assign xfer = key_bit_valid && ready_reg;

    // State and output registers; reset discards any partial key immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            par_reg       <= 1'b0;
            cnt_reg       <= '0;
            stall_reg     <= '0;
            rel_reg       <= '0;
            key_out_reg   <= '0;
            key_valid_reg <= 1'b0;
            fsm_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            par_reg       <= par_next;
            cnt_reg       <= cnt_next;
            stall_reg     <= stall_next;
            rel_reg       <= rel_next;
            key_out_reg   <= key_out_next;
            key_valid_reg <= key_valid_next;
            fsm_rst_reg   <= fsm_rst_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
        end
    end

    // Next-state logic; registered outputs are decoded from the next state
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        par_next       = par_reg;
        cnt_next       = cnt_reg;
        stall_next     = stall_reg;
        rel_next       = rel_reg;
        key_out_next   = key_out_reg;
        key_valid_next = key_valid_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_LOAD;
                    shreg_next = '0;
                    cnt_next   = '0;
                    stall_next = '0;
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    stall_next = '0;
                    if (cnt_reg == CW'(KEY_W)) begin
                        par_next   = key_bit;
                        state_next = S_CHECK;
                    end else begin
                        // Loop-based bit select keeps the index width independent of KEY_W
                        for (int i = 0; i < KEY_W; i++) begin
                            if (cnt_reg == CW'(i)) begin
                                shreg_next[i] = key_bit;
                            end
                        end
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (stall_reg == TW'(TIMEOUT - 1)) begin
                    state_next = S_ERROR;
                end else begin
                    stall_next = stall_reg + TW'(1);
                end
            end
            S_CHECK: begin
                if (((^shreg_reg) ^ par_reg) == 1'b0) begin
                    key_out_next   = shreg_reg;
                    key_valid_next = 1'b1;
                    rel_next       = RW'(RELEASE_CYC);
                    state_next     = S_RELEASE;
                end else begin
                    state_next = S_ERROR;
                end
            end
            S_RELEASE: begin
                if (rel_reg == RW'(1)) begin
                    state_next = S_RUN;
                end else begin
                    rel_next = rel_reg - RW'(1);
                end
            end
            S_RUN: begin
                // rekey takes priority over start, which is ignored here anyway
                if (rekey) begin
                    state_next     = S_LOAD;
                    key_out_next   = '0;
                    key_valid_next = 1'b0;
                    shreg_next     = '0;
                    cnt_next       = '0;
                    stall_next     = '0;
                end
            end
            S_ERROR: begin
                if (start) begin
                    state_next = S_LOAD;
                    shreg_next = '0;
                    cnt_next   = '0;
                    stall_next = '0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Entering ERROR always withdraws the key from the locked FSM
        if (state_next == S_ERROR) begin
            key_out_next   = '0;
            key_valid_next = 1'b0;
        end

        ready_next   = (state_next == S_LOAD);
        busy_next    = (state_next == S_LOAD) || (state_next == S_CHECK) ||
                       (state_next == S_RELEASE);
        err_next     = (state_next == S_ERROR);
        fsm_rst_next = (state_next != S_RUN);
    end

    assign key_bit_ready = ready_reg;
    assign key_out       = key_out_reg;
    assign key_out_valid = key_valid_reg;
    assign fsm_rst       = fsm_rst_reg;
    assign busy          = busy_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_key_load_sequencer.sv
// Directed testbench for key_load_sequencer with default parameters.
module tb_key_load_sequencer;

    localparam int KEY_W       = 8;
    localparam int RELEASE_CYC = 4;
    localparam int TIMEOUT     = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             rekey = 1'b0;
    logic             key_bit_valid = 1'b0;
    logic             key_bit = 1'b0;
    logic             key_bit_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_out_valid;
    logic             fsm_rst;
    logic             busy;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    key_load_sequencer #(
        .KEY_W      (KEY_W),
        .RELEASE_CYC(RELEASE_CYC),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rekey        (rekey),
        .key_bit_valid(key_bit_valid),
        .key_bit      (key_bit),
        .key_bit_ready(key_bit_ready),
        .key_out      (key_out),
        .key_out_valid(key_out_valid),
        .fsm_rst      (fsm_rst),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] k, input int lo, input int hi);
        logic [7:0] kv;
        kv = k;
        for (int i = lo; i <= hi; i++) begin
            key_bit_valid = 1'b1;
            key_bit       = kv[i];
            tick();
        end
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
    endtask

    task automatic send_par(input logic p);
        key_bit_valid = 1'b1;
        key_bit       = p;
        tick();
        key_bit_valid = 1'b0;
        key_bit       = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ready"}, 32'(key_bit_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Called right after the parity transfer (DUT in CHECK)
    task automatic release_check(input string tag, input logic [7:0] k);
        chk({tag, "_chk_ready"}, 32'(key_bit_ready), 0);
        tick();
        chk({tag, "_key"}, 32'(key_out), 32'(k));
        chk({tag, "_kvalid"}, 32'(key_out_valid), 1);
        chk({tag, "_rel_rst0"}, 32'(fsm_rst), 1);
        for (int i = 1; i < RELEASE_CYC; i++) begin
            tick();
            chk({tag, "_rel_rst"}, 32'(fsm_rst), 1);
        end
        tick();
        chk({tag, "_run_rst"}, 32'(fsm_rst), 0);
        chk({tag, "_run_busy"}, 32'(busy), 0);
        chk({tag, "_run_key"}, 32'(key_out), 32'(k));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_key"}, 32'(key_out), 0);
        chk({tag, "_kvalid"}, 32'(key_out_valid), 0);
        chk({tag, "_fsm_rst"}, 32'(fsm_rst), 1);
        chk({tag, "_ready"}, 32'(key_bit_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        tick();

        // 1: load 0xA5 with correct parity
        do_start("t1");
        send_bits(8'hA5, 0, 7);
        send_par(1'b0);
        chk("t1_check_kvalid", 32'(key_out_valid), 0);
        release_check("t1", 8'hA5);

        // 4: rekey from RUN, then load 0x3C
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        chk("t4_rekey_rst", 32'(fsm_rst), 1);
        chk("t4_rekey_key", 32'(key_out), 0);
        chk("t4_rekey_kvalid", 32'(key_out_valid), 0);
        chk("t4_rekey_ready", 32'(key_bit_ready), 1);
        send_bits(8'h3C, 0, 7);
        send_par(1'b0);
        release_check("t4", 8'h3C);

        // 6: start and stray valid in RUN are ignored
        start = 1'b1;
        key_bit_valid = 1'b1;
        tick();
        start = 1'b0;
        key_bit_valid = 1'b0;
        tick();
        chk("t6_run_rst", 32'(fsm_rst), 0);
        chk("t6_run_key", 32'(key_out), 32'h3C);
        chk("t6_run_busy", 32'(busy), 0);
        chk("t6_run_ready", 32'(key_bit_ready), 0);

        // 2: bad parity -> ERROR; rekey ignored in ERROR; restart passes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        do_start("t2a");
        send_bits(8'hA5, 0, 7);
        send_par(1'b1);
        tick();
        chk("t2_err", 32'(err), 1);
        chk("t2_key", 32'(key_out), 0);
        chk("t2_kvalid", 32'(key_out_valid), 0);
        chk("t2_fsm_rst", 32'(fsm_rst), 1);
        chk("t2_busy", 32'(busy), 0);
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        chk("t6_err_rekey_err", 32'(err), 1);
        chk("t6_err_rekey_ready", 32'(key_bit_ready), 0);
        do_start("t2b");
        send_bits(8'hA5, 0, 7);
        send_par(1'b0);
        release_check("t2b", 8'hA5);

        // 3a: 254 stalled cycles (with start/rekey pulses inside) are tolerated
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        send_bits(8'h5A, 0, 3);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            start = (i == 10);
            rekey = (i == 20);
            tick();
        end
        start = 1'b0;
        rekey = 1'b0;
        chk("t3a_ready", 32'(key_bit_ready), 1);
        chk("t3a_err", 32'(err), 0);
        send_bits(8'h5A, 4, 7);
        send_par(1'b0);
        release_check("t3a", 8'h5A);

        // 3b: 255 stalled cycles -> ERROR on the last one
        rekey = 1'b1;
        tick();
        rekey = 1'b0;
        send_bits(8'h5A, 0, 3);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
        end
        chk("t3b_pre_err", 32'(err), 0);
        chk("t3b_pre_ready", 32'(key_bit_ready), 1);
        tick();
        chk("t3b_err", 32'(err), 1);
        chk("t3b_ready", 32'(key_bit_ready), 0);
        chk("t3b_key", 32'(key_out), 0);
        tick();
        chk("t3b_ready_after", 32'(key_bit_ready), 0);

        // 5: async reset after 5 bits, then clean reload of 0x0F
        do_start("t5a");
        send_bits(8'hFF, 0, 4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        tick();
        rst = 1'b0;
        tick();
        do_start("t5b");
        send_bits(8'h0F, 0, 7);
        send_par(1'b0);
        release_check("t5b", 8'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
